// File: rtl/nonrestoring_div.sv
// ============================================================================
//  Module      : nonrestoring_div
//  Description : Sequential non-restoring divider, one quotient bit per clock.
//                Define BOOTH_DIV_SIGNED_EN for two's-complement operands.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nonrestoring_div #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   a_step;
   logic [WIDTH-1:0] a_fix;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;

`ifdef BOOTH_DIV_SIGNED_EN
   logic neg_q_q, neg_q_d;
   logic neg_r_q, neg_r_d;

   assign dividend_mag = dividend[WIDTH-1] ? (-dividend) : dividend;
   assign divisor_mag  = divisor[WIDTH-1]  ? (-divisor)  : divisor;
   // Truncating division: quotient sign is the XOR, remainder follows the dividend.
   assign q_res = neg_q_q ? (-acc_q) : acc_q;
   assign r_res = neg_r_q ? (-a_fix) : a_fix;
`else
   assign dividend_mag = dividend;
   assign divisor_mag  = divisor;
   assign q_res        = acc_q;
   assign r_res        = a_fix;
`endif

   // Partial remainder carries a sign bit; A:Q shift feeds the top quotient bit into A.
   assign a_shift = {a_q[WIDTH-1:0], acc_q[WIDTH-1]};
   assign a_step  = a_q[WIDTH] ? (a_shift + {1'b0, d_q}) : (a_shift - {1'b0, d_q});
   assign a_fix   = a_q[WIDTH] ? (a_q[WIDTH-1:0] + d_q) : a_q[WIDTH-1:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      acc_d       = acc_q;
      d_d         = d_q;
      dvd_d       = dvd_q;
      zero_d      = zero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
`ifdef BOOTH_DIV_SIGNED_EN
      neg_q_d     = neg_q_q;
      neg_r_d     = neg_r_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvd_d  = dividend;
               d_d    = divisor_mag;
               acc_d  = dividend_mag;
               a_d    = '0;
               cnt_d  = '0;
               zero_d = (divisor == '0);
`ifdef BOOTH_DIV_SIGNED_EN
               neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               neg_r_d = dividend[WIDTH-1];
`endif
               // A zero divisor skips iteration; FIX loads the saturated result.
               state_d = (divisor == '0) ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            a_d   = a_step;
            acc_d = {acc_q[WIDTH-2:0], ~a_step[WIDTH]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (zero_q) begin
               quotient_d  = '1;
               remainder_d = dvd_q;
               div_zero_d  = 1'b1;
            end else begin
               quotient_d  = q_res;
               remainder_d = r_res;
               div_zero_d  = 1'b0;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         acc_q       <= '0;
         d_q         <= '0;
         dvd_q       <= '0;
         zero_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
`ifdef BOOTH_DIV_SIGNED_EN
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         acc_q       <= acc_d;
         d_q         <= d_d;
         dvd_q       <= dvd_d;
         zero_q      <= zero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
`ifdef BOOTH_DIV_SIGNED_EN
         neg_q_q     <= neg_q_d;
         neg_r_q     <= neg_r_d;
`endif
      end
   end

   assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
   assign done      = (state_q == S_DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_nonrestoring_div.sv
// ============================================================================
//  Module      : tb_nonrestoring_div
//  Description : Directed bench for nonrestoring_div (WIDTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nonrestoring_div;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] q_o, r_o;
   logic         dz_o;
   int           lat;
   logic         seen_done;

   nonrestoring_div #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one division from IDLE, returns the result and edge count to done,
   // then steps past the pulse so the next start lands in IDLE.
   task automatic run(input logic [W-1:0] n, input logic [W-1:0] d,
                      output logic [W-1:0] q, output logic [W-1:0] r,
                      output logic dz, output int edges);
      dividend = n;
      divisor  = d;
      start    = 1'b1;
      step();
      start = 1'b0;
      edges = 1;
      while (done !== 1'b1 && edges < 20) begin
         step();
         edges++;
      end
      q  = quotient;
      r  = remainder;
      dz = div_zero;
      step();
      chk("done_fall", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      step();
      step();
      rst = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_q", quotient, 32'd0);
      chk("rst_r", remainder, 32'd0);
      chk("rst_dz", {31'd0, div_zero}, 32'd0);

      // 13/3
      run(4'd13, 4'd3, q_o, r_o, dz_o, lat);
      chk("t1_lat", lat, 32'd6);
      chk("t1_q", q_o, 32'd4);
      chk("t1_r", r_o, 32'd1);
      chk("t1_dz", {31'd0, dz_o}, 32'd0);
      chk("t1_busy_after", {31'd0, busy}, 32'd0);

      // 7/0 then 15/15
      run(4'd7, 4'd0, q_o, r_o, dz_o, lat);
      chk("t2_lat", lat, 32'd2);
      chk("t2_q", q_o, 32'hF);
      chk("t2_r", r_o, 32'd7);
      chk("t2_dz", {31'd0, dz_o}, 32'd1);
      chk("t2_dz_hold", {31'd0, div_zero}, 32'd1);
      run(4'd15, 4'd15, q_o, r_o, dz_o, lat);
      chk("t2b_q", q_o, 32'd1);
      chk("t2b_r", r_o, 32'd0);
      chk("t2b_dz", {31'd0, dz_o}, 32'd0);

      // 13/3 with 9/2 starts pulsed while busy
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      step();
      dividend = 4'd9;
      divisor  = 4'd2;
      step();
      chk("t3_busy_e2", {31'd0, busy}, 32'd1);
      start = 1'b0;
      step();
      chk("t3_q_hold", quotient, 32'd1);
      step();
      start = 1'b1;
      step();
      chk("t3_busy_e5", {31'd0, busy}, 32'd1);
      start = 1'b0;
      step();
      chk("t3_done", {31'd0, done}, 32'd1);
      chk("t3_q", quotient, 32'd4);
      chk("t3_r", remainder, 32'd1);
      step();

      // reset mid-division
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_busy", {31'd0, busy}, 32'd0);
      chk("t4_done", {31'd0, done}, 32'd0);
      chk("t4_q", quotient, 32'd0);
      chk("t4_r", remainder, 32'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (done === 1'b1) seen_done = 1'b1;
      end
      chk("t4_no_done", {31'd0, seen_done}, 32'd0);

      // exhaustive unsigned sweep
      for (int n = 0; n < 16; n++) begin
         for (int d = 0; d < 16; d++) begin
            run(n[W-1:0], d[W-1:0], q_o, r_o, dz_o, lat);
            if (d == 0) begin
               chk($sformatf("sweep_lat %0d/%0d", n, d), lat, 32'd2);
               chk($sformatf("sweep_q %0d/%0d", n, d), q_o, 32'hF);
               chk($sformatf("sweep_r %0d/%0d", n, d), r_o, n);
               chk($sformatf("sweep_dz %0d/%0d", n, d), {31'd0, dz_o}, 32'd1);
            end else begin
               chk($sformatf("sweep_lat %0d/%0d", n, d), lat, 32'd6);
               chk($sformatf("sweep_q %0d/%0d", n, d), q_o, n / d);
               chk($sformatf("sweep_r %0d/%0d", n, d), r_o, n % d);
               chk($sformatf("sweep_dz %0d/%0d", n, d), {31'd0, dz_o}, 32'd0);
            end
         end
      end

`ifdef BOOTH_DIV_SIGNED_EN
      run(4'h9, 4'd2, q_o, r_o, dz_o, lat);
      chk("s_m7_2_q", q_o, 32'hD);
      chk("s_m7_2_r", r_o, 32'hF);
      run(4'd7, 4'hE, q_o, r_o, dz_o, lat);
      chk("s_7_m2_q", q_o, 32'hD);
      chk("s_7_m2_r", r_o, 32'd1);
      run(4'h8, 4'hF, q_o, r_o, dz_o, lat);
      chk("s_ovf_q", q_o, 32'h8);
      chk("s_ovf_r", r_o, 32'd0);
      chk("s_ovf_dz", {31'd0, dz_o}, 32'd0);
      chk("s_ovf_lat", lat, 32'd6);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
